// File: rtl/mem_bus_ctrl_if.sv
// Bus between the core's memory port, the memory controller and its SRAM/IO side.
// The master modport is the core-plus-SRAM environment; the slave modport is the controller.
interface mem_bus_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              bus_err;
    logic              busy;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;
    logic [31:0]       io_out;

    modport master (
        output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, sram_rdata,
        input  cpu_rdata, cpu_ready, bus_err, busy,
        input  sram_en, sram_we, sram_addr, sram_wdata, io_out
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, sram_rdata,
        output cpu_rdata, cpu_ready, bus_err, busy,
        output sram_en, sram_we, sram_addr, sram_wdata, io_out
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-side controller for the multicycle MIPS core: latches one word request, runs it against
// a synchronous SRAM with programmable wait states or a single IO register, and reports errors.
module mem_bus_ctrl #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_ADDR     = 32'hFFFF_0000
) (
    input logic           clk,
    input logic           reset,
    mem_bus_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ERR
    } state_e;

    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sramAddr_q, sramAddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              isWrite_q, isWrite_d;
    logic              isIo_q, isIo_d;
    logic [3:0]        waitCnt_q, waitCnt_d;
    logic [31:0]       cpuRdata_q, cpuRdata_d;
    logic [31:0]       ioOut_q, ioOut_d;

    logic reqValid;
    logic reqIo;
    logic reqSram;
    logic reqErr;
    logic sramEn;

    // Request decode is only acted upon in IDLE; anything neither SRAM nor the IO word is unmapped.
    assign reqValid = bus.cpu_rd | bus.cpu_wr;
    assign reqIo    = (bus.cpu_addr == IO_ADDR);
    assign reqSram  = (bus.cpu_addr[31:ADDR_W+2] == '0);
    assign reqErr   = (bus.cpu_rd & bus.cpu_wr) | (bus.cpu_addr[1:0] != 2'b00) | (!reqSram && !reqIo);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sramAddr_q <= '0;
            wdata_q    <= '0;
            isWrite_q  <= 1'b0;
            isIo_q     <= 1'b0;
            waitCnt_q  <= '0;
            cpuRdata_q <= '0;
            ioOut_q    <= '0;
        end else begin
            state_q    <= state_d;
            sramAddr_q <= sramAddr_d;
            wdata_q    <= wdata_d;
            isWrite_q  <= isWrite_d;
            isIo_q     <= isIo_d;
            waitCnt_q  <= waitCnt_d;
            cpuRdata_q <= cpuRdata_d;
            ioOut_q    <= ioOut_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sramAddr_d = sramAddr_q;
        wdata_d    = wdata_q;
        isWrite_d  = isWrite_q;
        isIo_d     = isIo_q;
        waitCnt_d  = waitCnt_q;
        cpuRdata_d = cpuRdata_q;
        ioOut_d    = ioOut_q;

        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    sramAddr_d = bus.cpu_addr[ADDR_W+1:2];
                    wdata_d    = bus.cpu_wdata;
                    isWrite_d  = bus.cpu_wr;
                    isIo_d     = reqIo;
                    if (reqErr) begin
                        state_d = ERR;
                    end else begin
                        state_d   = ACCESS;
                        waitCnt_d = reqIo ? 4'd0 : WaitLoad;
                    end
                end
            end
            ACCESS: begin
                if (isIo_q) begin
                    state_d = DONE;
                    if (isWrite_q) begin
                        ioOut_d = wdata_q;
                    end else begin
                        cpuRdata_d = ioOut_q;
                    end
                end else if (waitCnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!isWrite_q) begin
                        cpuRdata_d = bus.sram_rdata;
                    end
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The counter still holds its load value only in the first ACCESS cycle, which gates the write strobe.
    assign sramEn         = (state_q == ACCESS) && !isIo_q;
    assign bus.sram_en    = sramEn;
    assign bus.sram_we    = sramEn && isWrite_q && (waitCnt_q == WaitLoad);
    assign bus.sram_addr  = sramAddr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.cpu_rdata  = cpuRdata_q;
    assign bus.cpu_ready  = (state_q == DONE) || (state_q == ERR);
    assign bus.bus_err    = (state_q == ERR);
    assign bus.busy       = (state_q != IDLE);
    assign bus.io_out     = ioOut_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one DUT with one wait state, one with none, both driven with
// identical core requests and each attached to its own SRAM model.
module tb_mem_bus_ctrl;

    localparam logic [31:0] IoAddr = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic reset;
    int   vectorCount = 0;
    int   miscompareCount = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.ADDR_W(10)) busA ();
    mem_bus_ctrl_if #(.ADDR_W(10)) busB ();

    mem_bus_ctrl #(.ADDR_W(10), .WAIT_STATES(1), .IO_ADDR(IoAddr)) dutA (
        .clk  (clk),
        .reset(reset),
        .bus  (busA)
    );

    mem_bus_ctrl #(.ADDR_W(10), .WAIT_STATES(0), .IO_ADDR(IoAddr)) dutB (
        .clk  (clk),
        .reset(reset),
        .bus  (busB)
    );

    // SRAM A registers its read data one cycle after enable; SRAM B reads combinationally
    // so the zero-wait-state controller can capture data in its single ACCESS cycle.
    logic [31:0] memA [1024];
    logic [31:0] memB [1024];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            memA[i] = 32'h0;
            memB[i] = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (busA.sram_en) begin
            if (busA.sram_we) memA[busA.sram_addr] <= busA.sram_wdata;
            busA.sram_rdata <= memA[busA.sram_addr];
        end
        if (busB.sram_en && busB.sram_we) memB[busB.sram_addr] <= busB.sram_wdata;
    end

    assign busB.sram_rdata = memB[busB.sram_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic setRequest(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        busA.cpu_rd    = rd;
        busA.cpu_wr    = wr;
        busA.cpu_addr  = addr;
        busA.cpu_wdata = wdata;
        busB.cpu_rd    = rd;
        busB.cpu_wr    = wr;
        busB.cpu_addr  = addr;
        busB.cpu_wdata = wdata;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " A rdata"}, busA.cpu_rdata, 32'h0);
        checkOutput({tag, " A io_out"}, busA.io_out, 32'h0);
        checkOutput({tag, " A sram_addr"}, 32'(busA.sram_addr), 32'h0);
        checkOutput({tag, " A sram_wdata"}, busA.sram_wdata, 32'h0);
        checkOutput({tag, " A ready"}, 32'(busA.cpu_ready), 32'h0);
        checkOutput({tag, " A bus_err"}, 32'(busA.bus_err), 32'h0);
        checkOutput({tag, " A sram_en"}, 32'(busA.sram_en), 32'h0);
        checkOutput({tag, " A sram_we"}, 32'(busA.sram_we), 32'h0);
        checkOutput({tag, " A busy"}, 32'(busA.busy), 32'h0);
        checkOutput({tag, " B rdata"}, busB.cpu_rdata, 32'h0);
        checkOutput({tag, " B io_out"}, busB.io_out, 32'h0);
        checkOutput({tag, " B ready"}, 32'(busB.cpu_ready), 32'h0);
        checkOutput({tag, " B sram_we"}, 32'(busB.sram_we), 32'h0);
        checkOutput({tag, " B busy"}, 32'(busB.busy), 32'h0);
    endtask

    // Request is presented in cycle N (entered just after a rising edge); cycles N+1..N+5 are observed.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit isErr, input bit pulseBusy,
                                 input int latA, input int latB, input int enA, input int enB,
                                 input logic [31:0] rdataA, input logic [31:0] rdataB);
        int readyCntA = 0, readyCycA = 0, errCntA = 0, enCntA = 0, weCntA = 0, weCycA = 0;
        int readyCntB = 0, readyCycB = 0, errCntB = 0, enCntB = 0, weCntB = 0, weCycB = 0;
        logic [31:0] weAddrA = '0, weDataA = '0, weAddrB = '0, weDataB = '0;
        int expWe;
        expWe = (wr && !isErr && addr != IoAddr) ? 1 : 0;

        setRequest(rd, wr, addr, wdata);
        @(posedge clk);
        #1;
        if (pulseBusy) setRequest(1'b0, 1'b1, 32'h14, 32'hDEAD_BEEF);
        else setRequest(1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput({tag, " A busy"}, 32'(busA.busy), 32'h1);
                checkOutput({tag, " B busy"}, 32'(busB.busy), 32'h1);
            end
            if (busA.cpu_ready) begin readyCntA++; readyCycA = c; end
            if (busA.bus_err) errCntA++;
            if (busA.sram_en) enCntA++;
            if (busA.sram_we) begin
                weCntA++; weCycA = c; weAddrA = 32'(busA.sram_addr); weDataA = busA.sram_wdata;
            end
            if (busB.cpu_ready) begin readyCntB++; readyCycB = c; end
            if (busB.bus_err) errCntB++;
            if (busB.sram_en) enCntB++;
            if (busB.sram_we) begin
                weCntB++; weCycB = c; weAddrB = 32'(busB.sram_addr); weDataB = busB.sram_wdata;
            end
            @(posedge clk);
            #1;
            if (c == 1) setRequest(1'b0, 1'b0, 32'h0, 32'h0);
        end

        checkOutput({tag, " A ready cycle"}, readyCycA, latA);
        checkOutput({tag, " A ready pulses"}, readyCntA, 1);
        checkOutput({tag, " A bus_err"}, errCntA, isErr ? 1 : 0);
        checkOutput({tag, " A sram_en cycles"}, enCntA, enA);
        checkOutput({tag, " A sram_we cycles"}, weCntA, expWe);
        checkOutput({tag, " A rdata"}, busA.cpu_rdata, rdataA);
        checkOutput({tag, " A idle"}, 32'(busA.busy), 32'h0);
        checkOutput({tag, " B ready cycle"}, readyCycB, latB);
        checkOutput({tag, " B ready pulses"}, readyCntB, 1);
        checkOutput({tag, " B bus_err"}, errCntB, isErr ? 1 : 0);
        checkOutput({tag, " B sram_en cycles"}, enCntB, enB);
        checkOutput({tag, " B sram_we cycles"}, weCntB, expWe);
        checkOutput({tag, " B rdata"}, busB.cpu_rdata, rdataB);
        checkOutput({tag, " B idle"}, 32'(busB.busy), 32'h0);
        if (expWe == 1) begin
            checkOutput({tag, " A we cycle"}, weCycA, 1);
            checkOutput({tag, " A we addr"}, weAddrA, {22'h0, addr[11:2]});
            checkOutput({tag, " A we data"}, weDataA, wdata);
            checkOutput({tag, " B we cycle"}, weCycB, 1);
            checkOutput({tag, " B we addr"}, weAddrB, {22'h0, addr[11:2]});
            checkOutput({tag, " B we data"}, weDataB, wdata);
        end
    endtask

    initial begin
        int abortReady;
        reset = 1'b1;
        setRequest(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        //               tag        rd    wr    addr          wdata         err  pulse latA latB enA enB rdataA        rdataB
        applyStimulus("wr 0x10",   1'b0, 1'b1, 32'h10,       32'h12345678, 0,   0,    3,   2,   2,  1,  32'h0,        32'h0);
        applyStimulus("rd 0x10",   1'b1, 1'b0, 32'h10,       32'h0,        0,   0,    3,   2,   2,  1,  32'h12345678, 32'h12345678);
        applyStimulus("wr IO",     1'b0, 1'b1, IoAddr,       32'hA5,       0,   0,    2,   2,   0,  0,  32'h12345678, 32'h12345678);
        checkOutput("A io_out", busA.io_out, 32'hA5);
        checkOutput("B io_out", busB.io_out, 32'hA5);
        applyStimulus("rd IO",     1'b1, 1'b0, IoAddr,       32'h0,        0,   0,    2,   2,   0,  0,  32'hA5,       32'hA5);
        applyStimulus("rd 0x13",   1'b1, 1'b0, 32'h13,       32'h0,        1,   0,    1,   1,   0,  0,  32'hA5,       32'hA5);
        applyStimulus("wr unmap",  1'b0, 1'b1, 32'h0001_0000, 32'h77,      1,   0,    1,   1,   0,  0,  32'hA5,       32'hA5);
        applyStimulus("rd&wr",     1'b1, 1'b1, 32'h20,       32'h55,       1,   0,    1,   1,   0,  0,  32'hA5,       32'hA5);
        applyStimulus("busy pulse", 1'b1, 1'b0, 32'h10,      32'h0,        0,   1,    3,   2,   2,  1,  32'h12345678, 32'h12345678);
        checkOutput("A io_out kept", busA.io_out, 32'hA5);

        // Reset lands in the first ACCESS cycle of a write: strobes and IO must drop at once.
        setRequest(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        setRequest(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("abort A we before reset", 32'(busA.sram_we), 32'h1);
        checkOutput("abort B we before reset", 32'(busB.sram_we), 32'h1);
        reset = 1'b1;
        #1;
        checkResetState("abort");
        @(posedge clk);
        #1;
        reset = 1'b0;
        abortReady = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (busA.cpu_ready || busB.cpu_ready) abortReady++;
            @(posedge clk);
            #1;
        end
        checkOutput("abort ready pulses", abortReady, 0);
        applyStimulus("rd after abort", 1'b1, 1'b0, 32'h10, 32'h0, 0, 0, 3, 2, 2, 1, 32'h12345678, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
